// File: rtl/a2_time_pulse_ring_pkg.sv
`default_nettype none
// ============================================================================
// Module      : a2_time_pulse_ring_pkg
// Description : Shared constants for the timer time-pulse ring.
// Revision    : 1.0 - initial release
// ============================================================================
package a2_time_pulse_ring_pkg;

    // Default ring geometry and timing
    localparam int N_PULSES_DEF   = 12;
    localparam int MCT_W_DEF      = 16;
    localparam int CT_TIMEOUT_DEF = 64;

    // Bit positions of the first and last time pulse in the one-hot ring
    localparam int T01_IDX = 0;
    localparam int T12_IDX = N_PULSES_DEF - 1;

    // Ring value after reset: parked on T12 so the first CT edge lands on T01
    localparam logic [N_PULSES_DEF-1:0] T_RST = {1'b1, {(N_PULSES_DEF-1){1'b0}}};

endpackage : a2_time_pulse_ring_pkg
`default_nettype wire

// File: rtl/a2_ct_edge.sv
`default_nettype none
// ============================================================================
// Module      : a2_ct_edge
// Description : CT rising-edge detector with a stall watchdog. The watchdog
//               raises a sticky alarm when no CT edge arrives for
//               CT_TIMEOUT consecutive clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module a2_ct_edge #(
    parameter int CT_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ct,
    output logic o_ct_rise,
    output logic o_osc_alarm
);

    localparam int WD_W = $clog2(CT_TIMEOUT + 1);
    localparam logic [WD_W-1:0] c_WD_MAX  = WD_W'(CT_TIMEOUT);
    localparam logic [WD_W-1:0] c_WD_TRIP = WD_W'(CT_TIMEOUT - 1);

    logic            r_ct_q;
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_osc_alarm;
    logic            w_ct_rise;

    // ct_q resets high so a CT already high at reset release is not an edge
    assign w_ct_rise = i_ct & ~r_ct_q;

    // Delayed CT, watchdog counter and sticky stall alarm
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ct_q      <= 1'b1;
            r_wd_cnt    <= '0;
            r_osc_alarm <= 1'b0;
        end else begin
            r_ct_q <= i_ct;
            if (w_ct_rise) begin
                r_wd_cnt <= '0;
            end else begin
                if (r_wd_cnt != c_WD_MAX) begin
                    r_wd_cnt <= r_wd_cnt + WD_W'(1);
                end
                if (r_wd_cnt == c_WD_TRIP) begin
                    r_osc_alarm <= 1'b1;
                end
            end
        end
    end

    assign o_ct_rise   = w_ct_rise;
    assign o_osc_alarm = r_osc_alarm;

endmodule : a2_ct_edge
`default_nettype wire

// File: rtl/a2_time_pulse_ring.sv
`default_nettype none
// ============================================================================
// Module      : a2_time_pulse_ring
// Description : One-hot time-pulse ring T01..T12 stepped by CT rising edges.
//               Handles GOJAM restart, STOP hold at T12, end-of-MCT strobe,
//               MCT counter and sticky phase/oscillator alarms.
// Revision    : 1.0 - initial release
// ============================================================================
module a2_time_pulse_ring
    import a2_time_pulse_ring_pkg::*;
#(
    parameter int N_PULSES   = N_PULSES_DEF,
    parameter int MCT_W      = MCT_W_DEF,
    parameter int CT_TIMEOUT = CT_TIMEOUT_DEF
) (
    input  logic                SIM_CLK,
    input  logic                SIM_RST,
    input  logic                PHS2,
    input  logic                PHS4,
    input  logic                CT,
    input  logic                GOJAM,
    input  logic                STOP,
    output logic [N_PULSES-1:0] T,
    output logic                EOT,
    output logic [MCT_W-1:0]    MCT_CNT,
    output logic                STOPPED,
    output logic                OSC_ALARM,
    output logic                PHS_ALARM
);

    localparam int                  c_T12_IDX = N_PULSES - 1;
    localparam logic [N_PULSES-1:0] c_T_RST   = {1'b1, {(N_PULSES-1){1'b0}}};
    localparam logic [N_PULSES-1:0] c_T_T01   = N_PULSES'(1) << T01_IDX;

    logic                w_ct_rise;
    logic                w_osc_alarm;
    logic [N_PULSES-1:0] r_t;
    logic                r_eot;
    logic [MCT_W-1:0]    r_mct_cnt;
    logic                r_stopped;
    logic                r_phs_alarm;
    logic                r_gojam_pend;

    a2_ct_edge #(
        .CT_TIMEOUT (CT_TIMEOUT)
    ) u_ct_edge (
        .clk         (SIM_CLK),
        .rst         (SIM_RST),
        .i_ct        (CT),
        .o_ct_rise   (w_ct_rise),
        .o_osc_alarm (w_osc_alarm)
    );

    // Ring, GOJAM latch, MCT counter and EOT strobe; all ring moves wait for a CT edge
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            r_t          <= c_T_RST;
            r_eot        <= 1'b0;
            r_mct_cnt    <= '0;
            r_stopped    <= 1'b0;
            r_gojam_pend <= 1'b0;
        end else begin
            r_eot <= 1'b0;
            if (GOJAM) begin
                r_gojam_pend <= 1'b1;
            end
            if (w_ct_rise) begin
                if (r_gojam_pend || GOJAM) begin
                    // Restart wins over everything and consumes the pending request
                    r_t          <= c_T_T01;
                    r_mct_cnt    <= '0;
                    r_stopped    <= 1'b0;
                    r_gojam_pend <= 1'b0;
                end else if (r_t[c_T12_IDX] && STOP) begin
                    r_stopped <= 1'b1;
                end else if (r_t[c_T12_IDX]) begin
                    r_t       <= c_T_T01;
                    r_eot     <= 1'b1;
                    r_mct_cnt <= r_mct_cnt + MCT_W'(1);
                    r_stopped <= 1'b0;
                end else begin
                    r_t <= {r_t[N_PULSES-2:0], r_t[c_T12_IDX]};
                end
            end
        end
    end

    // Sticky flag for overlapping clock phases
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            r_phs_alarm <= 1'b0;
        end else if (PHS2 && PHS4) begin
            r_phs_alarm <= 1'b1;
        end
    end

    assign T         = r_t;
    assign EOT       = r_eot;
    assign MCT_CNT   = r_mct_cnt;
    assign STOPPED   = r_stopped;
    assign OSC_ALARM = w_osc_alarm;
    assign PHS_ALARM = r_phs_alarm;

endmodule : a2_time_pulse_ring
`default_nettype wire
